// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//
// Four-source prioritised interrupt controller with a small register port.
// Peripherals raise irq_in flags; rising edges latch into PENDING. When the
// global enable is set and an enabled source is pending, the lowest-numbered
// one is presented to the CPU on irq_req/irq_vector. On irq_ack the source is
// marked in service, its pending bit is cleared and irq_clr pulses for one
// cycle back to the peripheral. iret ends service and re-arms arbitration.
//
// Ports
//   clk          in   system clock, rising-edge
//   rst          in   synchronous active-high reset
//   irq_in[3:0]  in   peripheral interrupt flags, bit 0 highest priority
//   irq_clr[3:0] out  one-cycle clear pulse to the serviced peripheral
//   cs           in   register-port select
//   address[1:0] in   register index (0 ENABLE, 1 PENDING, 2 STATUS, 3 SWTRIG)
//   din[7:0]     in   write data
//   w_en         in   write strobe (qualified by cs)
//   r_en         in   read strobe (qualified by cs)
//   dout[7:0]    out  registered read data, one-cycle latency
//   irq_req      out  interrupt request to the CPU
//   irq_vector   out  index of the requested source
//   irq_ack      in   CPU accepts irq_req
//   iret         in   CPU finished servicing
// ---------------------------------------------------------------------------
module irq_ctrl #(
  parameter logic [3:0] RESET_ENABLE = 4'b0000,
  parameter logic       RESET_GIE    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_in,
  output logic [3:0] irq_clr,
  input  logic       cs,
  input  logic [1:0] address,
  input  logic [7:0] din,
  input  logic       w_en,
  input  logic       r_en,
  output logic [7:0] dout,
  output logic       irq_req,
  output logic [1:0] irq_vector,
  input  logic       irq_ack,
  input  logic       iret
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_SWTRIG  = 2'd3;

  state_t     state_q, state_d;
  logic [3:0] enable_q, enable_d;
  logic       gie_q, gie_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] irqHist_q, irqHist_d;
  logic [3:0] armed_q, armed_d;
  logic [1:0] vector_q, vector_d;
  logic       req_q, req_d;
  logic [3:0] clr_q, clr_d;
  logic [7:0] dout_q, dout_d;

  logic       wrEn;
  logic       rdEn;
  logic [3:0] hwSet;
  logic [3:0] swSet;
  logic [3:0] w1cMask;
  logic [3:0] ackMask;
  logic [3:0] active;
  logic [1:0] lowestIdx;
  logic [7:0] readData;
  logic       unusedDin;

  assign wrEn = cs & w_en;
  assign rdEn = cs & r_en;

  // din[6:4] has no meaning in any register.
  assign unusedDin = ^din[6:4];

  // Edge detection on the registered copy of irq_in. A source only becomes
  // armed once it has been seen low after reset, so a flag that is held high
  // through reset does not produce a spurious pending bit when reset drops.
  always_comb begin
    hwSet     = irq_in & ~irqHist_q & armed_q;
    irqHist_d = irq_in;
    armed_d   = armed_q | ~irq_in;
  end

  // Register-port write decode. ENABLE updates the enable/GIE registers,
  // PENDING writes clear bits, SWTRIG writes set bits, STATUS is read-only.
  always_comb begin
    enable_d = enable_q;
    gie_d    = gie_q;
    w1cMask  = 4'b0000;
    swSet    = 4'b0000;
    if (wrEn) begin
      unique case (address)
        ADDR_ENABLE: begin
          enable_d = din[3:0];
          gie_d    = din[7];
        end
        ADDR_PENDING: w1cMask = din[3:0];
        ADDR_SWTRIG:  swSet   = din[3:0];
        default: ;
      endcase
    end
  end

  // Priority pick among enabled pending sources; the loop runs from the
  // lowest priority upward so the last hit is the highest-priority index.
  always_comb begin
    active    = pending_q & enable_q;
    lowestIdx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (active[i]) begin
        lowestIdx = 2'(i);
      end
    end
  end

  // Request/service FSM. Arbitration in IDLE uses the registered enables, so
  // an ENABLE write only affects it a cycle later. The withdrawal check in REQ
  // looks at the enables being written this cycle so a disabled request drops
  // immediately, while a simultaneous irq_ack still wins.
  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    req_d    = req_q;
    clr_d    = 4'b0000;
    ackMask  = 4'b0000;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (gie_q && (active != 4'b0000)) begin
          state_d  = REQ;
          vector_d = lowestIdx;
          req_d    = 1'b1;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d            = SERVICE;
          req_d              = 1'b0;
          ackMask[vector_q]  = 1'b1;
          clr_d[vector_q]    = 1'b1;
        end else if (!gie_d || !enable_d[vector_q]) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      SERVICE: begin
        req_d = 1'b0;
        if (iret) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Pending update: acknowledgement and write-1-to-clear remove bits first,
  // then hardware and software sets are OR-ed in so a coincident set wins.
  always_comb begin
    pending_d = ((pending_q & ~ackMask) & ~w1cMask) | hwSet | swSet;
  end

  // Read mux sampled into dout on a read strobe; dout holds otherwise.
  always_comb begin
    readData = 8'h00;
    unique case (address)
      ADDR_ENABLE:  readData = {gie_q, 3'b000, enable_q};
      ADDR_PENDING: readData = {4'b0000, pending_q};
      ADDR_STATUS:  readData = {2'b00, (state_q == SERVICE), req_q, 2'b00, vector_q};
      ADDR_SWTRIG:  readData = 8'h00;
      default:      readData = 8'h00;
    endcase
    dout_d = rdEn ? readData : dout_q;
  end

  // All state registers. Reset aborts any request or service in progress
  // without issuing a clear pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      enable_q  <= RESET_ENABLE;
      gie_q     <= RESET_GIE;
      pending_q <= 4'b0000;
      irqHist_q <= 4'b0000;
      armed_q   <= 4'b0000;
      vector_q  <= 2'd0;
      req_q     <= 1'b0;
      clr_q     <= 4'b0000;
      dout_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      gie_q     <= gie_d;
      pending_q <= pending_d;
      irqHist_q <= irqHist_d;
      armed_q   <= armed_d;
      vector_q  <= vector_d;
      req_q     <= req_d;
      clr_q     <= clr_d;
      dout_q    <= dout_d;
    end
  end

  assign irq_req    = req_q;
  assign irq_vector = vector_q;
  assign irq_clr    = clr_q;
  assign dout       = dout_q;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter RESET_ENABLE, default 4'b0000, SHALL give the reset value of the per-source enable bits.
REQ-002 Parameter RESET_GIE, default 1'b0, SHALL give the reset value of the global interrupt enable.
REQ-003 clk  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 irq_in  in  4  peripheral interrupt flags; bit 0 is highest priority.
REQ-006 irq_clr  out  4  one-cycle pulse clearing the serviced peripheral flag.
REQ-007 cs  in  1  register-port select.
REQ-008 address  in  2  register index.
REQ-009 din  in  8  write data.
REQ-010 w_en  in  1  write strobe, qualified by cs.
REQ-011 r_en  in  1  read strobe, qualified by cs.
REQ-012 dout  out  8  registered read data.
REQ-013 irq_req  out  1  interrupt request to the CPU.
REQ-014 irq_vector  out  2  index of the requested source.
REQ-015 irq_ack  in  1  one-cycle CPU acceptance of irq_req.
REQ-016 iret  in  1  one-cycle end-of-service pulse from the CPU.

Function
REQ-017 Register map SHALL be: 0 ENABLE (rw; [3:0] enables, [7] GIE, [6:4] read 0); 1 PENDING (r [3:0]; write-1-to-clear); 2 STATUS (r; [1:0] vector, [4] irq_req, [5] in_service; writes ignored); 3 SWTRIG (write-1 sets pending; reads 0).
REQ-018 Pending bit i SHALL set on the cycle after a 0->1 transition of irq_in[i], using a registered copy of irq_in.
REQ-019 When a hardware or SWTRIG set coincides with a PENDING write-1-to-clear of the same bit, set SHALL win.
REQ-020 The FSM SHALL have three states: IDLE, REQ and SERVICE.
REQ-021 IDLE -> REQ SHALL occur when GIE=1 and (pending & enable) != 0; irq_vector latches the lowest set index, and irq_req=1 from the next cycle.
REQ-022 In REQ, irq_req and irq_vector SHALL be held stable until irq_ack.
REQ-023 REQ -> SERVICE on irq_ack: irq_req=0, pending[vector] cleared, and irq_clr[vector]=1 for exactly that one following cycle.
REQ-024 In REQ, if GIE or enable[vector] is cleared without irq_ack, the FSM SHALL return to IDLE with irq_req=0 next cycle and pending retained.
REQ-025 irq_ack in the same cycle as a withdrawal SHALL take precedence, and the transition to SERVICE proceeds.
REQ-026 In SERVICE, no new request SHALL be issued; pending bits keep accumulating; iret -> IDLE.
REQ-027 irq_ack outside REQ and iret outside SERVICE SHALL be ignored.
REQ-028 A higher-priority source becoming pending while in REQ SHALL NOT change irq_vector; it is arbitrated after return to IDLE.
REQ-029 Register reads SHALL have one-cycle latency: dout updates on the cycle after cs&r_en and holds otherwise.
REQ-030 A write to ENABLE SHALL take effect for arbitration on the following cycle.

Reset
REQ-031 On rst: state=IDLE, pending=0, enable=RESET_ENABLE, GIE=RESET_GIE, irq_req=0, irq_vector=0, irq_clr=0, dout=0, irq_in history=0.
REQ-032 rst mid-REQ or mid-SERVICE SHALL abort with no irq_clr pulse.
REQ-033 An irq_in held high through reset SHALL NOT set pending until it falls and rises again.

Verification
REQ-034 ENABLE=8'h8F; pulse irq_in=4'b0100 -> irq_req=1, irq_vector=2 two cycles later; irq_ack -> irq_clr=4'b0100 for one cycle, STATUS=8'h22.
REQ-035 irq_in 4'b1010 rising together with all enabled -> vector=1; ack and iret -> vector=3 requested next.
REQ-036 In REQ with vector=0, write ENABLE=8'h0E -> irq_req=0 next cycle, PENDING=8'h01; write 8'h8F -> request reissues with vector=0.
REQ-037 Same cycle: SWTRIG write 8'h01 and PENDING write 8'h01 -> PENDING reads 8'h01.
REQ-038 Assert rst while in SERVICE with irq_in=4'b1111 held -> all outputs 0 and PENDING=0 held until irq_in toggles.
REQ-039 In SERVICE, trigger source 0 -> no irq_req until iret, then vector=0 within two cycles.
